// File: rtl/instr_fetch.sv
// Fetch stage: in-order instruction memory requests with credit-limited issue, a small
// instruction FIFO and redirect flush. Optional macro IF_MISALIGN_CHECK_EN adds fetch_misalign.
module instr_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc
`ifdef IF_MISALIGN_CHECK_EN
  ,
  output logic        fetch_misalign
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW+1:0] DEPTH_W = (CW+2)'(FIFO_DEPTH);
  localparam logic [CW-1:0] ONE     = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] ZERO    = {CW{1'b0}};

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FETCH = 2'd1, S_DRAIN = 2'd2} state_t;
  state_t state, state_next;

  logic [31:0]   fetch_pc, rsp_pc, last_instr, last_pc, redirect_aligned;
  logic [CW-1:0] count, live, discard, pending, discard_redir, discard_next;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [31:0]   fifo_data [FIFO_DEPTH];
  logic [31:0]   fifo_pc   [FIFO_DEPTH];
  logic          halt, credit_ok, req_fire, rsp_drop, rsp_keep, pop;

  assign redirect_aligned = {redirect_pc[31:2], 2'b00};
  // Every issued request reserves a FIFO slot until its response is kept or dropped.
  assign credit_ok = ({2'b00, count} + {2'b00, live} + {2'b00, discard}) < DEPTH_W;
  assign req_fire  = mem_req_valid && mem_req_ready;
  assign rsp_drop  = mem_rsp_valid && (discard != ZERO);
  assign rsp_keep  = mem_rsp_valid && !redirect_valid && (discard == ZERO) && (live != ZERO);
  assign pop       = instr_valid && instr_ready && !redirect_valid;
  assign pending   = discard + live;
  assign discard_redir = (mem_rsp_valid && (pending != ZERO)) ? pending - ONE : pending;
  assign discard_next  = redirect_valid ? discard_redir : (rsp_drop ? discard - ONE : discard);

  assign mem_req_addr = fetch_pc;
  assign instruction  = (count != ZERO) ? fifo_data[rd_ptr] : last_instr;
  assign instr_pc     = (count != ZERO) ? fifo_pc[rd_ptr]   : last_pc;

`ifdef IF_MISALIGN_CHECK_EN
  logic misalign;
  assign halt           = misalign;
  assign fetch_misalign = misalign;

  // Misaligned redirect halts issue until an aligned redirect arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign <= 1'b0;
    end else if (redirect_valid) begin
      misalign <= |redirect_pc[1:0];
    end
  end
`else
  logic unused_pc_bits;
  assign halt           = 1'b0;
  assign unused_pc_bits = ^redirect_pc[1:0];
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: drain whenever stale responses are still owed.
  always_comb begin
    state_next = S_IDLE;
    case (state)
      S_IDLE, S_FETCH, S_DRAIN: state_next = (discard_next != ZERO) ? S_DRAIN : S_FETCH;
      default:                  state_next = S_IDLE;
    endcase
  end

  // Handshake outputs.
  always_comb begin
    mem_req_valid = 1'b0;
    instr_valid   = 1'b0;
    if (state != S_IDLE) begin
      mem_req_valid = !redirect_valid && !halt && credit_ok;
    end else begin
      mem_req_valid = 1'b0;
    end
    instr_valid = (count != ZERO);
  end

  // PCs, credit counters and FIFO pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc   <= RESET_PC;
      rsp_pc     <= RESET_PC;
      live       <= ZERO;
      discard    <= ZERO;
      count      <= ZERO;
      wr_ptr     <= {AW{1'b0}};
      rd_ptr     <= {AW{1'b0}};
      last_instr <= 32'h0000_0000;
      last_pc    <= 32'h0000_0000;
    end else begin
      if (count != ZERO) begin
        last_instr <= fifo_data[rd_ptr];
        last_pc    <= fifo_pc[rd_ptr];
      end
      if (redirect_valid) begin
        fetch_pc <= redirect_aligned;
        rsp_pc   <= redirect_aligned;
        live     <= ZERO;
        discard  <= discard_redir;
        count    <= ZERO;
        wr_ptr   <= {AW{1'b0}};
        rd_ptr   <= {AW{1'b0}};
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (rsp_keep) begin
          rsp_pc <= rsp_pc + 32'd4;
          wr_ptr <= wr_ptr + {{(AW-1){1'b0}}, 1'b1};
        end
        if (pop) rd_ptr <= rd_ptr + {{(AW-1){1'b0}}, 1'b1};
        live    <= live  + (req_fire ? ONE : ZERO) - (rsp_keep ? ONE : ZERO);
        count   <= count + (rsp_keep ? ONE : ZERO) - (pop ? ONE : ZERO);
        discard <= discard_next;
      end
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    if (rsp_keep && !rst) begin
      fifo_data[wr_ptr] <= mem_rsp_data;
      fifo_pc[wr_ptr]   <= rsp_pc;
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: behavioural memory + in-order PC stream model, checked every cycle,
// plus directed scenarios with literal expectations.
module tb_instr_fetch;
  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic clk = 1'b0, rst = 1'b1;
  logic mem_req_valid, mem_req_ready = 1'b1, mem_rsp_valid = 1'b0;
  logic [31:0] mem_req_addr, mem_rsp_data = 32'h0, redirect_pc = 32'h0;
  logic redirect_valid = 1'b0, instr_valid, instr_ready = 1'b1;
  logic [31:0] instruction, instr_pc;
`ifdef IF_MISALIGN_CHECK_EN
  logic fetch_misalign;
`endif

  instr_fetch #(.RESET_PC(RST_PC), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instruction(instruction), .instr_pc(instr_pc)
`ifdef IF_MISALIGN_CHECK_EN
    , .fetch_misalign(fetch_misalign)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0, lat = 1, n_req = 0, n_pop = 0, rel_cyc = 0, first_pop_cyc = 0;
  logic [31:0] exp_req, exp_out, first_pop_pc, first_pop_instr, first_req_addr;
  bit after_rst = 1'b0, after_redir = 1'b0, halted = 1'b0, got_first_pop = 1'b0, got_first_req = 1'b0;
  logic [31:0] mq_addr [$];
  int          mq_due  [$];

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, ~a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Memory: answers accepted requests in order after lat cycles.
  always @(negedge clk) begin
    if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = word_of(mq_addr[0]);
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = 32'hDEAD_BEEF;
    end
  end

  // Compare process: sampled just before each rising edge.
  always @(negedge clk) begin
    #4;
    if (after_rst) begin
      check("rst_req_valid", 32'(mem_req_valid), 32'd0);
      check("rst_req_addr", mem_req_addr, RST_PC);
      check("rst_instr_valid", 32'(instr_valid), 32'd0);
      check("rst_instruction", instruction, 32'd0);
      check("rst_instr_pc", instr_pc, 32'd0);
      if (!rst) rel_cyc = cyc;
    end
    if (after_redir) check("redir_flush_valid", 32'(instr_valid), 32'd0);
    if (mem_req_valid) check("req_addr_aligned", 32'(mem_req_addr[1:0]), 32'd0);
    if (rst) begin
      mq_addr.delete(); mq_due.delete();
      exp_req = RST_PC; exp_out = RST_PC; halted = 1'b0;
      n_req = 0; n_pop = 0; got_first_pop = 1'b0; got_first_req = 1'b0;
    end else if (redirect_valid) begin
      check("redir_no_req", 32'(mem_req_valid), 32'd0);
      if (mem_rsp_valid) begin void'(mq_addr.pop_front()); void'(mq_due.pop_front()); end
      exp_req = {redirect_pc[31:2], 2'b00};
      exp_out = {redirect_pc[31:2], 2'b00};
`ifdef IF_MISALIGN_CHECK_EN
      halted = |redirect_pc[1:0];
`endif
      got_first_pop = 1'b0; got_first_req = 1'b0;
    end else begin
      if (halted) check("halt_no_req", 32'(mem_req_valid), 32'd0);
      if (mem_rsp_valid) begin void'(mq_addr.pop_front()); void'(mq_due.pop_front()); end
      if (mem_req_valid && mem_req_ready) begin
        check("req_addr", mem_req_addr, exp_req);
        if (!got_first_req) begin first_req_addr = mem_req_addr; got_first_req = 1'b1; end
        mq_addr.push_back(mem_req_addr); mq_due.push_back(cyc + lat);
        exp_req += 32'd4; n_req++;
      end
      if (instr_valid && instr_ready) begin
        check("instr_pc", instr_pc, exp_out);
        check("instruction", instruction, word_of(exp_out));
        if (!got_first_pop) begin
          first_pop_pc = instr_pc; first_pop_instr = instruction;
          first_pop_cyc = cyc; got_first_pop = 1'b1;
        end
        exp_out += 32'd4; n_pop++;
      end
    end
    after_rst   = rst;
    after_redir = redirect_valid && !rst;
    cyc++;
  end

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_pop(input string name, input int bound);
    for (int i = 0; i < bound && !got_first_pop; i++) @(negedge clk);
    check(name, 32'(got_first_pop), 32'd1);
  endtask

  task automatic wait_req(input string name, input int n, input int bound);
    for (int i = 0; i < bound && n_req < n; i++) @(negedge clk);
    check(name, 32'(n_req >= n), 32'd1);
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1'b1; redirect_pc = pc;
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  initial begin
    int n0;
    // 1: streaming from reset
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_pop("t1_timeout", 20);
    check("t1_first_pc", first_pop_pc, 32'h0000_0100);
    check("t1_first_instr", first_pop_instr, 32'hC1DE_FEFF);
    check("t1_latency", 32'(first_pop_cyc - rel_cyc), 32'd3);
    n0 = n_pop;
    repeat (8) @(negedge clk);
    check("t1_rate", 32'(n_pop - n0), 32'd8);

    // 2: back-pressure fills the FIFO
    instr_ready = 1'b0;
    do_reset();
    repeat (12) @(negedge clk);
    check("t2_req_count", 32'(n_req), 32'd4);
    check("t2_req_stopped", 32'(mem_req_valid), 32'd0);
    check("t2_head_valid", 32'(instr_valid), 32'd1);
    check("t2_head_pc", instr_pc, 32'h0000_0100);
    instr_ready = 1'b1;
    repeat (10) @(negedge clk);
    check("t2_pops", 32'(n_pop >= 4), 32'd1);
    check("t2_fetch_resumed", 32'(n_req > 4), 32'd1);

    // 3: redirect with two requests in flight
    lat = 3;
    do_reset();
    wait_req("t3_timeout_req", 2, 20);
    redirect(32'h0000_0200);
    wait_pop("t3_timeout_pop", 30);
    check("t3_first_pc", first_pop_pc, 32'h0000_0200);
    check("t3_first_instr", first_pop_instr, 32'hC2DE_FDFF);

    // 4: redirect coinciding with a response
    lat = 1;
    do_reset();
    for (int i = 0; i < 20 && n_pop < 2; i++) @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    #1;
    check("t4_rsp_coincide", 32'(mem_rsp_valid), 32'd1);
    check("t4_no_req", 32'(mem_req_valid), 32'd0);
    @(negedge clk);
    redirect_valid = 1'b0;
    wait_pop("t4_timeout_pop", 30);
    check("t4_first_req", first_req_addr, 32'h0000_0200);
    check("t4_first_pc", first_pop_pc, 32'h0000_0200);

    // 5: reset mid-stream with 3 entries buffered and 1 in flight
    instr_ready = 1'b0;
    do_reset();
    wait_req("t5_timeout_req", 4, 20);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    check("t5_req_valid", 32'(mem_req_valid), 32'd1);
    check("t5_req_addr", mem_req_addr, RST_PC);
    instr_ready = 1'b1;
    repeat (6) @(negedge clk);

`ifdef IF_MISALIGN_CHECK_EN
    // 6: misaligned redirect halts, aligned redirect resumes
    redirect(32'h0000_0203);
    n0 = n_req;
    repeat (6) @(negedge clk);
    check("t6_misalign_set", 32'(fetch_misalign), 32'd1);
    check("t6_no_reqs", 32'(n_req - n0), 32'd0);
    redirect(32'h0000_0300);
    #1;
    check("t6_misalign_clr", 32'(fetch_misalign), 32'd0);
    check("t6_req_valid", 32'(mem_req_valid), 32'd1);
    check("t6_req_addr", mem_req_addr, 32'h0000_0300);
    repeat (6) @(negedge clk);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage directly upstream of the instruction field parser.
- Issues word-aligned reads to instruction memory over a valid/ready request channel and accepts in-order responses.
- Buffers fetched words with their PCs in a small FIFO, and presents one 32-bit instruction plus its PC to the parser/decode stage with a valid/ready handshake.
- Supports a redirect input (branch/jump) that flushes buffered and in-flight fetches.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset; must be word-aligned.
- FIFO_DEPTH, 4, instruction buffer entries; power of 2, minimum 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_req_valid  out  1  fetch request valid.
- mem_req_ready  in  1  memory accepts the request this cycle.
- mem_req_addr  out  32  fetch byte address; bits [1:0] are always 0.
- mem_rsp_valid  in  1  response data valid. Responses are in request order and are never back-pressured.
- mem_rsp_data  in  32  fetched instruction word.
- redirect_valid  in  1  flush the pipeline and restart fetch at redirect_pc.
- redirect_pc  in  32  new fetch address.
- instr_valid  out  1  instruction/instr_pc are valid.
- instr_ready  in  1  downstream consumes the head entry.
- instruction  out  32  FIFO head word; feeds the parser's instruction input.
- instr_pc  out  32  PC of the head word.

Behaviour:
- **Reset (clk edge with rst=1):**
  - fetch_pc=RESET_PC, rsp_pc=RESET_PC.
  - FIFO emptied; live=0, discard=0; state=S_IDLE.
  - Outputs: mem_req_valid=0, mem_req_addr=RESET_PC, instr_valid=0, instruction=0, instr_pc=0.
  - Reset mid-operation abandons all in-flight requests. The memory side is reset together with this block, so no stale responses are expected afterwards.
- **States:**
  - S_IDLE: one cycle after reset, no requests; always goes to S_FETCH.
  - S_FETCH: normal operation, discard==0.
  - S_DRAIN: discard>0; arriving responses are dropped. Returns to S_FETCH when discard reaches 0.
- **Request issue:**
  - mem_req_valid = (state!=S_IDLE) && !redirect_valid && (count+live+discard < FIFO_DEPTH).
  - mem_req_addr = fetch_pc.
  - On a handshake: fetch_pc += 4 (wraps modulo 2^32) and live += 1.
  - Requests may issue in S_DRAIN.
- **Response:**
  - If discard>0: discard -= 1 and the data is dropped.
  - Otherwise: push {mem_rsp_data, rsp_pc} into the FIFO, rsp_pc += 4, live -= 1.
  - The credit rule guarantees the FIFO is never full when a kept response arrives.
  - Push and pop in the same cycle are both legal.
- **Output:**
  - instr_valid = FIFO not empty; instruction/instr_pc are driven from the head entry.
  - Latency: response at cycle N gives instr_valid at N+1 (empty FIFO case).
  - Pop on instr_valid && instr_ready. When empty, instruction/instr_pc hold their last value (0 after reset).
- **Redirect (redirect_valid=1):** highest priority; no request issued that cycle.
  - FIFO flushed; instr_valid=0 the next cycle.
  - fetch_pc=rsp_pc=redirect_pc with bits [1:0] cleared.
  - discard = discard + live − (mem_rsp_valid ? 1 : 0); live=0.
  - A response arriving in the same cycle is dropped.
  - Next state: S_DRAIN if the new discard>0, else S_FETCH.
  - A redirect in S_IDLE is accepted and takes effect the same way.
- **Counters:** count/live/discard are each log2(FIFO_DEPTH)+1 bits and never exceed FIFO_DEPTH.
- **Protocol error:** mem_rsp_valid while live==0 and discard==0 is a protocol error; the response is ignored.

Optional Feature:
- Macro: IF_MISALIGN_CHECK_EN.
- **Defined:**
  - Adds output fetch_misalign (1 bit, reset 0).
  - A redirect with redirect_pc[1:0]!=0 flushes as normal, sets fetch_misalign=1, and holds mem_req_valid=0 until a later aligned redirect clears it.
  - Drain of stale responses continues while halted.
- **Undefined:** no extra port; redirect_pc[1:0] is silently forced to 0.

Test Plan:
1. RESET_PC=0x100, mem_req_ready=1, 1-cycle response latency, instr_ready=1 -> requests at 0x100,0x104,0x108...; first instr_valid with instr_pc=0x100 and instruction equal to the word returned for 0x100; one instruction per cycle thereafter.
2. instr_ready=0 after reset -> exactly 4 requests issued, then mem_req_valid=0 with FIFO full. Raise instr_ready -> 0x100..0x10C delivered in order, and fetch resumes at 0x110.
3. Two requests in flight (0x100, 0x104) with a redirect to 0x200 -> both responses dropped (state S_DRAIN, then S_FETCH); first delivered instr_pc=0x200.
4. redirect_valid coinciding with mem_rsp_valid and mem_req_ready=1 -> no request that cycle, concurrent response dropped, discard=live−1; next request address 0x200.
5. rst asserted mid-stream with 3 FIFO entries and 1 in flight -> next cycle instr_valid=0 and mem_req_valid=0; one cycle later the request address is RESET_PC.
6. (IF_MISALIGN_CHECK_EN) redirect to 0x203 -> fetch_misalign=1 and no requests; redirect to 0x300 -> fetch_misalign=0 and a request at 0x300.
